// File: rtl/timer_alarm_scheduler.sv
// AHB-lite millisecond alarm scheduler: a shared prescaler drives up to four
// reload down-counters whose expiries set sticky pending/overrun flags and a masked IRQ.
module timer_alarm_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 32,
  parameter int CNT_W    = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        TIMER_IRQ
);

  localparam int PW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;

  logic              dp_valid_r, dp_write_r, dp_word_r;
  logic [2:0]        dp_addr_r;
  logic [PW-1:0]     presc_r;
  logic              tick_s;
  logic [NUM_CH-1:0] ctrl_r, mask_r, pend_r, ovr_r, expire_s;
  logic [NUM_CH-1:0] clr_pend_s, clr_ovr_s;
  logic [CNT_W-1:0]  period_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_r    [NUM_CH];
  ch_state_e         state_r  [NUM_CH];
  logic              irq_r;
  logic              wr_s, wr_ctrl_s, wr_stat_s, wr_mask_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  // Address phase capture; the data phase acts on these one cycle later.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_word_r  <= 1'b0;
      dp_addr_r  <= 3'd0;
    end else begin
      dp_valid_r <= HSEL & HREADY & (HTRANS != 2'b00);
      dp_write_r <= HWRITE;
      dp_word_r  <= (HSIZE == 3'b010);
      dp_addr_r  <= HADDR[4:2];
    end
  end

  assign wr_s      = dp_valid_r & dp_write_r & dp_word_r;
  assign wr_ctrl_s = wr_s & (dp_addr_r == 3'd0);
  assign wr_stat_s = wr_s & (dp_addr_r == 3'd1);
  assign wr_mask_s = wr_s & (dp_addr_r == 3'd2);
  assign tick_s    = (presc_r == PW'(PRESCALE));

  // Free-running ms prescaler, never restarted by software.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Expiry detection and write-one-to-clear masks.
  always_comb begin
    expire_s   = '0;
    clr_pend_s = '0;
    clr_ovr_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      expire_s[i] = (state_r[i] == CH_RUN) & tick_s & (period_r[i] != '0) &
                    (cnt_r[i] <= CNT_W'(1));
    end
    if (wr_stat_s) begin
      clr_pend_s = HWDATA[NUM_CH-1:0];
      clr_ovr_s  = HWDATA[8 +: NUM_CH];
    end else begin
      clr_pend_s = '0;
      clr_ovr_s  = '0;
    end
  end

  // Per-channel IDLE/RUN state machine and reload down-counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= CH_IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (state_r[i])
          CH_IDLE: begin
            if (wr_ctrl_s && HWDATA[i]) begin
              state_r[i] <= CH_RUN;
              cnt_r[i]   <= period_r[i];
            end
          end
          CH_RUN: begin
            if (expire_s[i]) begin
              cnt_r[i] <= period_r[i];
            end else if (tick_s && (period_r[i] != '0)) begin
              cnt_r[i] <= cnt_r[i] - CNT_W'(1);
            end
            if (wr_ctrl_s && !HWDATA[i]) begin
              state_r[i] <= CH_IDLE;
            end
          end
          default: state_r[i] <= CH_IDLE;
        endcase
      end
    end
  end

  // Software-visible registers; an expiry wins over a same-cycle clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_r <= '0;
      mask_r <= '0;
      pend_r <= '0;
      ovr_r  <= '0;
      irq_r  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_r[i] <= '0;
      end
    end else begin
      if (wr_ctrl_s) ctrl_r <= HWDATA[NUM_CH-1:0];
      if (wr_mask_s) mask_r <= HWDATA[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_s && (dp_addr_r == {1'b1, 2'(i)})) period_r[i] <= HWDATA[CNT_W-1:0];
      end
      pend_r <= (pend_r & ~clr_pend_s) | expire_s;
      ovr_r  <= (ovr_r & ~clr_ovr_s) | (expire_s & pend_r);
      irq_r  <= |(pend_r & mask_r);
    end
  end

  // Read mux from the registered address and current (pre-update) register values.
  always_comb begin
    rdata_s = '0;
    if (dp_valid_r && !dp_write_r) begin
      case (dp_addr_r)
        3'd0: rdata_s[NUM_CH-1:0] = ctrl_r;
        3'd1: begin
          rdata_s[NUM_CH-1:0]  = pend_r;
          rdata_s[8 +: NUM_CH] = ovr_r;
        end
        3'd2: rdata_s[NUM_CH-1:0] = mask_r;
        3'd3: rdata_s = '0;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (dp_addr_r == {1'b1, 2'(i)}) rdata_s[CNT_W-1:0] = period_r[i];
          end
        end
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  assign HRDATA    = rdata_s;
  assign HREADYOUT = 1'b1;
  assign TIMER_IRQ = irq_r;
  assign unused_s  = ^{HADDR, HWDATA};

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed bench for timer_alarm_scheduler: register-map vector table plus
// hand-timed sequences for expiry, overrun, collisions and reload timing.
module tb_timer_alarm_scheduler;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, TIMER_IRQ;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hro_low = 0;

  timer_alarm_scheduler #(.NUM_CH(4), .PRESCALE(32), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  always @(negedge HCLK) if (HREADYOUT !== 1'b1) hro_low <= hro_low + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                        input logic [1:0] tr);
    HSEL = 1'b1; HTRANS = tr; HADDR = a; HWRITE = 1'b1; HSIZE = sz;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0; HSIZE = sz;
    @(negedge HCLK);
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_wr(a, d, 3'b010, 2'b10);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_rd(a, 3'b010, d);
  endtask

  task automatic poll(input logic [31:0] m, input int budget, output int t, output logic [31:0] v);
    t = -1;
    v = 32'h0;
    for (int k = 0; k < budget; k++) begin
      rd(32'h04, v);
      if ((v & m) != 32'h0) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge HCLK);
  endtask

  task automatic stop_all();
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0000_0F0F);
  endtask

  logic [31:0] v;
  int t0, t1, t2, t3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
    HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset_hrdata", HRDATA, 32'h0);
    chk("reset_irq", {31'h0, TIMER_IRQ}, 32'h0);

    // {wr, addr, size, trans, wdata, expected read}
    vecs.push_back('{1'b0, 32'h00, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0C, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 3'b010, 2'b10, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 3'b010, 2'b10, 32'h0, 32'h0000_000F});
    vecs.push_back('{1'b0, 32'h08, 3'b000, 2'b10, 32'h0, 32'h0000_000F});
    vecs.push_back('{1'b1, 32'h08, 3'b010, 2'b10, 32'h0000_0005, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 3'b010, 2'b10, 32'h0, 32'h0000_0005});
    vecs.push_back('{1'b1, 32'h14, 3'b010, 2'b10, 32'hABCD_1234, 32'h0});
    vecs.push_back('{1'b0, 32'h14, 3'b010, 2'b10, 32'h0, 32'h0000_1234});
    vecs.push_back('{1'b0, 32'h18, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0C, 3'b010, 2'b10, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h0C, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 3'b000, 2'b10, 32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 3'b010, 2'b00, 32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h04, 3'b010, 2'b10, 32'h0000_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h14, 3'b010, 2'b10, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 3'b010, 2'b10, 32'h0, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].trans);
      end else begin
        bus_rd(vecs[i].addr, vecs[i].size, v);
        chk($sformatf("vec%0d_addr%02h", i, vecs[i].addr), v, vecs[i].exp);
      end
    end

    // Reset in the middle of channel 0 operation.
    wr(32'h10, 32'd5);
    wr(32'h08, 32'h1);
    wr(32'h00, 32'h1);
    wait_until(cyc + 200);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("rst_irq", {31'h0, TIMER_IRQ}, 32'h0);
    rd(32'h00, v); chk("rst_ctrl", v, 32'h0);
    rd(32'h08, v); chk("rst_mask", v, 32'h0);
    rd(32'h10, v); chk("rst_period0", v, 32'h0);
    rd(32'h04, v); chk("rst_status", v, 32'h0);
    wait_until(cyc + 330);
    rd(32'h04, v); chk("rst_status_10ms", v, 32'h0);
    chk("rst_irq_10ms", {31'h0, TIMER_IRQ}, 32'h0);

    // Basic periodic alarm on channel 0.
    wr(32'h10, 32'd3);
    wr(32'h08, 32'h1);
    wr(32'h00, 32'h1);
    t0 = cyc;
    poll(32'h1, 150, t1, v);
    chk_rng("basic_first_latency", t1 - t0, 66, 99);
    chk("basic_irq_lags", {31'h0, TIMER_IRQ}, 32'h0);
    @(negedge HCLK);
    chk("basic_irq_set", {31'h0, TIMER_IRQ}, 32'h1);
    wr(32'h04, 32'h1);
    chk("basic_irq_before_clear", {31'h0, TIMER_IRQ}, 32'h1);
    rd(32'h04, v);
    chk("basic_status_cleared", v, 32'h0);
    chk("basic_irq_cleared", {31'h0, TIMER_IRQ}, 32'h0);
    poll(32'h1, 150, t2, v);
    chk_rng("basic_interval", t2 - t1, 99, 99);
    stop_all();

    // Overrun on channel 1 with a 1 ms period.
    wr(32'h14, 32'd1);
    wr(32'h00, 32'h2);
    poll(32'h2, 80, t1, v);
    chk("ovr_first", v, 32'h0000_0002);
    poll(32'h200, 80, t2, v);
    chk("ovr_second", v, 32'h0000_0202);
    chk_rng("ovr_interval", t2 - t1, 33, 33);
    wr(32'h04, 32'h0000_0202);
    rd(32'h04, v);
    chk("ovr_cleared", v, 32'h0);
    poll(32'h2, 80, t3, v);
    chk("ovr_after_clear", v, 32'h0000_0002);
    chk_rng("ovr_next_tick", t3 - t2, 33, 33);
    stop_all();

    // W1C data phase landing exactly on a channel 0 expiry.
    wr(32'h10, 32'd1);
    wr(32'h00, 32'h1);
    poll(32'h1, 80, t1, v);
    wait_until(t1 + 31);
    wr(32'h04, 32'h1);
    rd(32'h04, v);
    chk("collision_set_wins", v, 32'h0000_0101);
    stop_all();

    // Zero period inhibits channel 2.
    wr(32'h08, 32'h4);
    wr(32'h00, 32'h4);
    wait_until(cyc + 3300);
    rd(32'h04, v);
    chk("inhibit_status", v, 32'h0);
    chk("inhibit_irq", {31'h0, TIMER_IRQ}, 32'h0);
    stop_all();

    // Period rewrite while running only takes effect at the next reload.
    wr(32'h1C, 32'd10);
    wr(32'h00, 32'h8);
    t0 = cyc;
    wait_until(cyc + 40);
    wr(32'h1C, 32'd2);
    poll(32'h8, 400, t1, v);
    chk_rng("reload_first_interval", t1 - t0, 297, 330);
    wr(32'h04, 32'h8);
    poll(32'h8, 150, t2, v);
    chk_rng("reload_second_interval", t2 - t1, 66, 66);
    wr(32'h04, 32'h8);
    poll(32'h8, 150, t3, v);
    chk_rng("reload_third_interval", t3 - t2, 66, 66);
    stop_all();

    chk("hreadyout_always_high", hro_low, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_alarm_scheduler.md
Name: timer_alarm_scheduler

Overview:
- AHB-lite slave on the cycle-computer SoC bus. It schedules periodic millisecond alarms for up to 4 software tasks, for example display refresh, sensor timeout and 3 s idle.
- A single shared ms prescaler drives per-channel 16-bit reload down-counters. Expiry sets sticky pending flags. A masked OR of the pending flags drives an interrupt to the processor.
- Firmware uses this block instead of polling the free-running timer.

Parameters:
- NUM_CH, 4, number of alarm channels (1..4).
- PRESCALE, 32, ms tick period is PRESCALE+1 HCLK cycles (33 cycles at 32.768 kHz).
- CNT_W, 16, width of the period registers and down-counters.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  reset, asynchronous, active-high.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready, qualifies the address phase.
- HWRITE  in  1  1 = write.
- HADDR  in  32  byte address; only HADDR[4:2] is decoded.
- HWDATA  in  32  write data, used in the data phase.
- HSIZE  in  3  transfer size; only word (3'b010) is accepted.
- HTRANS  in  2  transfer type; 2'b00 = idle.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  always 1, zero wait states.
- TIMER_IRQ  out  1  level interrupt, registered.

Behaviour:
- Reset (asynchronous on HRESET high) clears every register and counter: CTRL, STATUS, MASK, all PERIOD registers, counters, prescaler, registered address phase, TIMER_IRQ=0. HRDATA=0.
- Address phase is accepted when HSEL & HREADY & HTRANS!=00. HWRITE, HSIZE and HADDR[4:2] are registered. The data phase follows one cycle later.
- Writes with HSIZE!=word are ignored. Reads are allowed at any HSIZE and return the full word.
- Register map, selected by HADDR[4:2]:
  - 0 CTRL: RW. Bits [NUM_CH-1:0] are the channel enables.
  - 1 STATUS: reads pending in [3:0] and overrun in [11:8]. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 2 MASK: RW. Bits [NUM_CH-1:0] are the IRQ enables.
  - 3: reserved. Reads 0, writes ignored.
  - 4..7 PERIOD0..3: RW, CNT_W bits, value in ms. Slots at or above NUM_CH read 0.
- Read data is combinational from the registered address and the current register values. A read in the same cycle as an update returns the pre-update value.
- Prescaler:
  - Free-running 0..PRESCALE, wraps to 0.
  - tick=1 for one cycle when the count equals PRESCALE.
  - It is never restarted by software, so the first interval after enable is PERIOD-1 to PERIOD ms.
- Per-channel state machine (IDLE, RUN):
  - IDLE to RUN when the CTRL enable bit is written from 0 to 1. The counter loads PERIOD[i] in that cycle.
  - RUN to IDLE when the enable bit is written to 0. The counter holds its value; pending and overrun are not affected.
  - In RUN, on tick:
    - if PERIOD[i]==0: nothing happens, the channel is inhibited;
    - else if counter<=1: set pending[i], reload counter with PERIOD[i], and set overrun[i] if pending[i] was already 1;
    - else decrement the counter.
  - A PERIOD write while in RUN takes effect at the next reload only.
  - Rewriting an enable bit that is already 1 does not reload the counter.
- Simultaneous events in one cycle:
  - Expiry and a W1C of the same pending bit: set wins, pending stays 1.
  - Expiry and a disable write: the expiry is still recorded.
- TIMER_IRQ is the register of |(pending & MASK) and lags STATUS by 1 cycle.
- Counters are unsigned CNT_W bits. Decrement never wraps below 1 because the reload path takes precedence.

Test Plan:
- Reset mid-operation:
  - Stimulus: run channel 0 with PERIOD0=5 and CTRL=1, then assert HRESET for 1 cycle.
  - Required response: all reads return 0, TIMER_IRQ=0, and no pending bit sets during the following 10 ms.
- Basic periodic alarm:
  - Stimulus: PERIOD0=3, MASK=1, CTRL=1, then poll STATUS.
  - Required response: STATUS[0]=1 between 66 and 99 cycles after the CTRL write. TIMER_IRQ=1 one cycle after STATUS[0] sets.
  - Stimulus: write STATUS=1.
  - Required response: pending clears and TIMER_IRQ=0 after one cycle.
  - Required response: the next expiry occurs exactly 99 cycles after the previous one.
- Overrun:
  - Stimulus: PERIOD1=1, CTRL=2, never clear STATUS.
  - Required response: STATUS=0x002 after the first tick, then 0x202 after the second tick.
  - Stimulus: write STATUS=0x202.
  - Required response: STATUS reads 0 until the next tick.
- Set/clear collision:
  - Stimulus: time a W1C write of STATUS[0] so its data phase lands on a channel-0 expiry.
  - Required response: STATUS[0] reads 1 afterwards.
- Period inhibit and reload timing:
  - Stimulus: PERIOD2=0 with CTRL=4.
  - Required response: no pending for 100 ms.
  - Stimulus: while running with PERIOD3=10, rewrite PERIOD3=2.
  - Required response: the current interval is still 10 ms; subsequent intervals are 2 ms (66 cycles).
- Bus corner cases:
  - Stimulus: byte-size write to CTRL.
  - Required response: ignored.
  - Stimulus: read of address 0x0C.
  - Required response: returns 0.
  - Stimulus: transfer with HTRANS=00.
  - Required response: no effect.
  - Required response: HREADYOUT=1 throughout.
